// File: rtl/rev_rate_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : rev_rate_meter_if
// Description : Word stream carrying per-channel edge counts from
//               rev_rate_meter to a 16-bit style stb/ack consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rev_rate_meter_if #(
    parameter int COUNT_BITS = 16,
    parameter int CHAN_BITS  = 2
);
    logic [COUNT_BITS-1:0] out1;
    logic [CHAN_BITS-1:0]  out1_chan;
    logic                  out1_stb;
    logic                  out1_ack;

    // Producer side: presents words, consumer acknowledges them
    modport master (
        output out1,
        output out1_chan,
        output out1_stb,
        input  out1_ack
    );

    // Consumer side
    modport slave (
        input  out1,
        input  out1_chan,
        input  out1_stb,
        output out1_ack
    );
endinterface
`default_nettype wire

// File: rtl/rev_rate_meter.sv
`default_nettype none
// ============================================================================
// Module      : rev_rate_meter
// Description : Multi-channel revolution rate meter. Synchronises and
//               debounces CHANNELS sensor pins, counts filtered rising edges
//               per gate period, snapshots the counts at gate end and streams
//               them out one stb/ack word per channel, channel 0 first.
// Revision    : 1.0 - initial release
// ============================================================================
module rev_rate_meter #(
    parameter int CHANNELS        = 4,
    parameter int COUNT_BITS      = 16,
    parameter int GATE_CYCLES     = 50000000,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [CHANNELS-1:0] sensor,
    rev_rate_meter_if.master         out1_bus,
    output logic                     overrun
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_CHAN_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_GATE_BITS = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int c_DB_BITS   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [c_GATE_BITS-1:0] c_GATE_LAST = c_GATE_BITS'(GATE_CYCLES - 1);
    localparam logic [c_DB_BITS-1:0]   c_DB_LAST   = c_DB_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CHAN_BITS-1:0] c_IDX_LAST  = c_CHAN_BITS'(CHANNELS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [c_GATE_BITS-1:0]         r_gate;
    logic                           w_term;
    logic [CHANNELS*COUNT_BITS-1:0] w_cnt_flat;
    logic [COUNT_BITS-1:0]          r_snap [CHANNELS];

    state_t                         r_state;
    logic [c_CHAN_BITS-1:0]         r_idx;
    logic [c_CHAN_BITS-1:0]         w_idx_next;
    logic [COUNT_BITS-1:0]          w_next_word;
    logic [COUNT_BITS-1:0]          r_out1;
    logic [c_CHAN_BITS-1:0]         r_out1_chan;
    logic                           r_out1_stb;
    logic                           r_overrun;

    // Terminal cycle of the gate: counters clear, snapshot may be taken
    assign w_term = (r_gate == c_GATE_LAST);

    // Free-running gate counter 0..GATE_CYCLES-1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate <= '0;
        end else if (w_term) begin
            r_gate <= '0;
        end else begin
            r_gate <= r_gate + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel input path: synchroniser, debounce filter, edge counter
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic                  r_sync1;
        logic                  r_sync2;
        logic                  r_filt;
        logic [c_DB_BITS-1:0]  r_db;
        logic [COUNT_BITS-1:0] r_cnt;
        logic                  w_commit;
        logic                  w_rise;

        // The filter commits on the last of DEBOUNCE_CYCLES differing cycles;
        // a commit towards 1 is the edge, counted in that same cycle.
        assign w_commit = (r_sync2 != r_filt) && (r_db == c_DB_LAST);
        assign w_rise   = w_commit && r_sync2;

        // Two-flop synchroniser for the asynchronous pin
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= sensor[g];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce: filtered level follows only after a stable run of differences
        always_ff @(posedge clk) begin
            if (rst) begin
                r_filt <= 1'b0;
                r_db   <= '0;
            end else if (r_sync2 == r_filt) begin
                r_db <= '0;
            end else if (r_db == c_DB_LAST) begin
                r_filt <= r_sync2;
                r_db   <= '0;
            end else begin
                r_db <= r_db + 1'b1;
            end
        end

        // Saturating edge counter; an edge in the terminal cycle opens the new gate
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_term) begin
                r_cnt <= COUNT_BITS'(w_rise);
            end else if (w_rise && !(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_cnt_flat[g*COUNT_BITS +: COUNT_BITS] = r_cnt;
    end

    // Snapshot bank: copied at gate end only when no frame is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_term && (r_state == S_IDLE)) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_snap[i] <= w_cnt_flat[i*COUNT_BITS +: COUNT_BITS];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output stream
    // ------------------------------------------------------------------------
    assign w_idx_next = r_idx + 1'b1;

    // Select the snapshot word for the channel that follows the current one
    always_comb begin
        w_next_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (c_CHAN_BITS'(i) == w_idx_next) begin
                w_next_word = r_snap[i];
            end
        end
    end

    // Frame sender FSM with registered stb/data/channel and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_out1      <= '0;
            r_out1_chan <= '0;
            r_out1_stb  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_term && (r_state == S_SEND)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_term) begin
                        // Channel 0 is taken straight from the counters, which
                        // are being copied into the bank on this same edge.
                        r_state     <= S_SEND;
                        r_idx       <= '0;
                        r_out1      <= w_cnt_flat[COUNT_BITS-1:0];
                        r_out1_chan <= '0;
                        r_out1_stb  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (r_out1_stb && out1_bus.out1_ack) begin
                        if (r_idx == c_IDX_LAST) begin
                            r_state    <= S_IDLE;
                            r_out1_stb <= 1'b0;
                        end else begin
                            r_idx       <= w_idx_next;
                            r_out1_chan <= w_idx_next;
                            r_out1      <= w_next_word;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_out1_stb <= 1'b0;
                end
            endcase
        end
    end

    assign out1_bus.out1      = r_out1;
    assign out1_bus.out1_chan = r_out1_chan;
    assign out1_bus.out1_stb  = r_out1_stb;
    assign overrun            = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rev_rate_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rev_rate_meter
// Description : Self-checking bench for rev_rate_meter. A cycle-level
//               behavioural model (gate position, debounce runs, expected
//               word queue) predicts every output; directed scenarios add
//               frame-level checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rev_rate_meter;

    localparam int CH      = 4;
    localparam int CB      = 8;
    localparam int GATE    = 200;
    localparam int DB      = 3;
    localparam int SATGATE = 4000;
    localparam int CMAX    = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          rst_sat;
    logic [CH-1:0] sensor;
    logic [CH-1:0] sat_sensor;
    logic          ack;
    logic          overrun;
    logic          sat_overrun;

    rev_rate_meter_if #(.COUNT_BITS(CB), .CHAN_BITS(2)) bus ();
    rev_rate_meter_if #(.COUNT_BITS(CB), .CHAN_BITS(2)) sat_bus ();

    assign bus.out1_ack     = ack;
    assign sat_bus.out1_ack = 1'b1;

    rev_rate_meter #(
        .CHANNELS(CH), .COUNT_BITS(CB), .GATE_CYCLES(GATE), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst(rst), .sensor(sensor), .out1_bus(bus), .overrun(overrun)
    );

    rev_rate_meter #(
        .CHANNELS(CH), .COUNT_BITS(CB), .GATE_CYCLES(SATGATE), .DEBOUNCE_CYCLES(DB)
    ) dut_sat (
        .clk(clk), .rst(rst_sat), .sensor(sat_sensor), .out1_bus(sat_bus), .overrun(sat_overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural reference model (advanced on every rising edge)
    // ------------------------------------------------------------------------
    int m_gate;
    int m_cnt  [CH];
    int m_filt [CH];
    int m_run  [CH];
    int m_d1   [CH];
    int m_d2   [CH];
    bit m_ovr;
    int m_q_val[$];
    int m_q_ch [$];

    task automatic model_step();
        bit busy;
        bit term;
        int synced;
        bit rise;
        if (rst) begin
            m_gate = 0;
            m_ovr  = 0;
            m_q_val.delete();
            m_q_ch.delete();
            for (int c = 0; c < CH; c++) begin
                m_cnt[c] = 0; m_filt[c] = 0; m_run[c] = 0; m_d1[c] = 0; m_d2[c] = 0;
            end
        end else begin
            busy = (m_q_val.size() > 0);
            term = (m_gate == GATE - 1);
            if (term) begin
                if (busy) m_ovr = 1;
                else begin
                    for (int c = 0; c < CH; c++) begin
                        m_q_val.push_back(m_cnt[c]);
                        m_q_ch.push_back(c);
                    end
                end
            end
            for (int c = 0; c < CH; c++) begin
                synced  = m_d2[c];
                m_d2[c] = m_d1[c];
                m_d1[c] = int'(sensor[c]);
                rise    = 0;
                if (synced != m_filt[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_filt[c] = synced;
                        m_run[c]  = 0;
                        rise      = (synced == 1);
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (term) m_cnt[c] = rise ? 1 : 0;
                else if (rise && m_cnt[c] < CMAX) m_cnt[c]++;
            end
            if (busy && ack) begin
                void'(m_q_val.pop_front());
                void'(m_q_ch.pop_front());
            end
            m_gate = term ? 0 : m_gate + 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Observed frames, captured at the transfer edge
    int obs_frame  [CH];
    int last_frame [CH];
    int obs_frames = 0;
    int sat_ch0    = 0;
    bit sat_done   = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst && bus.out1_stb && ack) begin
                obs_frame[bus.out1_chan] = int'(bus.out1);
                if (bus.out1_chan == 2'd3) begin
                    last_frame = obs_frame;
                    obs_frames++;
                end
            end
            if (!rst_sat && !sat_done && sat_bus.out1_stb && sat_bus.out1_chan == 2'd0) begin
                sat_ch0  = int'(sat_bus.out1);
                sat_done = 1;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("stb", 32'(bus.out1_stb), 32'(m_q_val.size() > 0));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (m_q_val.size() > 0) begin
                check("out1", 32'(bus.out1), 32'(m_q_val[0]));
                check("chan", 32'(bus.out1_chan), 32'(m_q_ch[0]));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gate_pos(input int p);
        int k = 0;
        while (m_gate != p && k < 2 * GATE) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2 * GATE) check("gate_pos_timeout", 0, 1);
    endtask

    task automatic wait_frame_after(input int base);
        int k = 0;
        while (obs_frames <= base && k < 6 * GATE) begin
            @(negedge clk);
            k++;
        end
        if (k >= 6 * GATE) check("frame_timeout", 0, 1);
    endtask

    task automatic pulse(input int c, input int hi, input int lo);
        sensor[c] = 1'b1;
        tick(hi);
        sensor[c] = 1'b0;
        tick(lo);
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    initial begin
        int base;
        int k;
        int runl [CH];
        int ack_hold;

        rst = 1'b1; rst_sat = 1'b1;
        sensor = '0; sat_sensor = '0; ack = 1'b1;
        tick(3);
        chk_en = 1;
        check("rst_out1", 32'(bus.out1), 0);
        check("rst_chan", 32'(bus.out1_chan), 0);
        check("rst_stb", 32'(bus.out1_stb), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_sat_stb", 32'(sat_bus.out1_stb), 0);
        rst = 1'b0; rst_sat = 1'b0;

        // Saturation: 300 clean pulses inside one long gate
        repeat (300) begin
            sat_sensor[0] = 1'b1; tick(4);
            sat_sensor[0] = 1'b0; tick(4);
        end
        k = 0;
        while (!sat_done && k < SATGATE) begin
            @(negedge clk);
            k++;
        end
        check("sat_done", 32'(sat_done), 1);
        check("sat_ch0", 32'(sat_ch0), 255);

        // Counting: five pulses on ch1
        wait_gate_pos(10);
        repeat (5) pulse(1, 10, 10);
        base = obs_frames;
        wait_frame_after(base);
        check("t1_ch0", 32'(last_frame[0]), 0);
        check("t1_ch1", 32'(last_frame[1]), 5);
        check("t1_ch2", 32'(last_frame[2]), 0);
        check("t1_ch3", 32'(last_frame[3]), 0);

        // Debounce: short glitches ignored, one long pulse counted
        wait_gate_pos(10);
        repeat (7) pulse(2, 2, 4);
        pulse(2, 6, 6);
        base = obs_frames;
        wait_frame_after(base);
        check("t2_ch2", 32'(last_frame[2]), 1);
        check("t2_ch1", 32'(last_frame[1]), 0);

        // Gate boundary: ch3 edge filtered exactly in the terminal cycle
        tick(20);
        base = obs_frames;
        wait_gate_pos(GATE - 5);
        sensor[3] = 1'b1; tick(10);
        sensor[3] = 1'b0; tick(10);
        wait_frame_after(base);
        check("t5_excluded", 32'(last_frame[3]), 0);
        wait_frame_after(base + 1);
        check("t5_next", 32'(last_frame[3]), 1);

        // Randomised traffic with glitches and random backpressure
        for (int c = 0; c < CH; c++) runl[c] = 0;
        ack_hold = 0;
        repeat (4000) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (runl[c] == 0) begin
                    sensor[c] = ~sensor[c];
                    runl[c]   = $urandom_range(1, 12);
                end else begin
                    runl[c]--;
                end
            end
            if (ack_hold > 0) begin
                ack = 1'b0;
                ack_hold--;
            end else if ($urandom_range(0, 999) < 3) begin
                ack_hold = $urandom_range(50, 300);
            end else begin
                ack = ($urandom_range(0, 9) != 0);
            end
        end
        sensor = '0; ack = 1'b1;
        tick(2 * GATE + 20);

        // Backpressure and overrun
        wait_gate_pos(10);
        pulse(0, 6, 6);
        pulse(0, 6, 6);
        wait_gate_pos(0);
        ack = 1'b0;
        tick(GATE + 3);
        check("t4_overrun", 32'(overrun), 1);
        check("t4_chan", 32'(bus.out1_chan), 0);
        check("t4_out1", 32'(bus.out1), 2);
        base = obs_frames;
        ack = 1'b1;
        wait_frame_after(base);
        check("t4_frame_ch0", 32'(last_frame[0]), 2);

        // Reset in the middle of a frame
        wait_gate_pos(0);
        wait_gate_pos(2);
        rst = 1'b1;
        tick(1);
        check("t6_stb", 32'(bus.out1_stb), 0);
        check("t6_overrun", 32'(overrun), 0);
        check("t6_out1", 32'(bus.out1), 0);
        rst = 1'b0;
        base = obs_frames;
        wait_frame_after(base);
        for (int c = 0; c < CH; c++) begin
            check("t6_zero", 32'(last_frame[c]), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
